decode_stage: RTL and testbench

- Parametrised successor to the single-cycle decode: the full ID stage of the in-order pipeline, between fetch (IF/ID) and execute (ID/EX).
- Contains the register file, immediate generator and control decode.
- Adds a registered ID/EX output with a valid/ready handshake, a load-use interlock, flush, and optional WB→ID bypass.
- Generalised over XLEN (RV32/RV64) and register count.

---
 rtl/decode_pkg.sv | 137 +++++++++++++
 rtl/decode_stage_if.sv | 63 ++++++
 rtl/decode_regfile.sv | 47 ++++
 rtl/decode_stage.sv | 205 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared definitions for the ID stage: RISC-V opcode values,
//               ALU-op encoding, immediate-format enum, the packed control
//               bundle and the opcode decode function.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam logic [6:0] c_OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE    = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL      = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR     = 7'b1100111;
    localparam logic [6:0] c_OPC_OP       = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_OPC_OP_32    = 7'b0111011;
    localparam logic [6:0] c_OPC_OP_IMM32 = 7'b0011011;

    localparam logic [1:0] c_ALUOP_ADD    = 2'b00;
    localparam logic [1:0] c_ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT  = 2'b10;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        ctrl_t    ctrl;
        imm_fmt_e fmt;
    } dec_t;

    // Unknown opcodes decode as R-format with every control bit cleared
    // except illegal, so nothing downstream writes state before the trap.
    function automatic dec_t decode_inst(input logic [31:0] inst, input logic rv64);
        dec_t d;
        d      = '0;
        d.fmt  = FMT_R;
        case (inst[6:0])
            c_OPC_LOAD: begin
                d.fmt           = FMT_I;
                d.ctrl.memread  = 1'b1;
                d.ctrl.memtoreg = 1'b1;
                d.ctrl.alusrc   = 1'b1;
                d.ctrl.regwrite = 1'b1;
            end
            c_OPC_STORE: begin
                d.fmt           = FMT_S;
                d.ctrl.memwrite = 1'b1;
                d.ctrl.alusrc   = 1'b1;
            end
            c_OPC_BRANCH: begin
                d.fmt          = FMT_B;
                d.ctrl.branch  = 1'b1;
                d.ctrl.aluop   = c_ALUOP_BRANCH;
            end
            c_OPC_OP: begin
                d.ctrl.regwrite = 1'b1;
                d.ctrl.aluop    = c_ALUOP_FUNCT;
            end
            c_OPC_OP_IMM: begin
                d.fmt           = FMT_I;
                d.ctrl.regwrite = 1'b1;
                d.ctrl.alusrc   = 1'b1;
                d.ctrl.aluop    = c_ALUOP_FUNCT;
            end
            c_OPC_OP_32: begin
                if (rv64) begin
                    d.ctrl.regwrite = 1'b1;
                    d.ctrl.aluop    = c_ALUOP_FUNCT;
                end else begin
                    d.ctrl.illegal  = 1'b1;
                end
            end
            c_OPC_OP_IMM32: begin
                if (rv64) begin
                    d.fmt           = FMT_I;
                    d.ctrl.regwrite = 1'b1;
                    d.ctrl.alusrc   = 1'b1;
                    d.ctrl.aluop    = c_ALUOP_FUNCT;
                end else begin
                    d.ctrl.illegal  = 1'b1;
                end
            end
            c_OPC_LUI, c_OPC_AUIPC: begin
                d.fmt           = FMT_U;
                d.ctrl.regwrite = 1'b1;
                d.ctrl.alusrc   = 1'b1;
            end
            c_OPC_JAL: begin
                d.fmt           = FMT_J;
                d.ctrl.regwrite = 1'b1;
                d.ctrl.alusrc   = 1'b1;
            end
            c_OPC_JALR: begin
                d.fmt           = FMT_I;
                d.ctrl.regwrite = 1'b1;
                d.ctrl.alusrc   = 1'b1;
            end
            default: d.ctrl.illegal = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic fmt_uses_rs1(input imm_fmt_e fmt);
        return (fmt != FMT_U) && (fmt != FMT_J);
    endfunction

    function automatic logic fmt_uses_rs2(input imm_fmt_e fmt);
        return (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    endfunction

    function automatic logic fmt_has_rd(input imm_fmt_e fmt);
        return (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_if
// Description : Bundle of the ID-stage handshakes: IF/ID input, ID/EX output,
//               write-back port, EX load interlock and flush.
//               slave  : seen by decode_stage
//               master : seen by the surrounding pipeline / environment
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic            out_branch;
    logic            out_memread;
    logic            out_memwrite;
    logic            out_memtoreg;
    logic            out_alusrc;
    logic            out_regwrite;
    logic [1:0]      out_aluop;
    logic            out_illegal;

    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_memread;
    logic [4:0]      ex_rd;

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        input  wb_valid, wb_rd, wb_data, ex_memread, ex_rd,
        output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
        output out_rs1, out_rs2, out_rd, out_funct3, out_funct7,
        output out_branch, out_memread, out_memwrite, out_memtoreg,
        output out_alusrc, out_regwrite, out_aluop, out_illegal
    );

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        output wb_valid, wb_rd, wb_data, ex_memread, ex_rd,
        input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
        input  out_rs1, out_rs2, out_rd, out_funct3, out_funct7,
        input  out_branch, out_memread, out_memwrite, out_memtoreg,
        input  out_alusrc, out_regwrite, out_aluop, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// ============================================================================
// Module      : decode_regfile
// Description : Architectural register file, 2 async read ports, 1 write
//               port, asynchronous active-low reset, x0 hardwired to zero.
//               Reads are read-before-write (old value during a write cycle).
// Ports       : clk, reset (active-low async)
//               raddr1_i/raddr2_i -> rdata1_o/rdata2_o
//               we_i, waddr_i, wdata_i (write port)
// Revision    : 1.0 - initial release
// ============================================================================
module decode_regfile #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic [4:0]      raddr1_i,
    input  wire logic [4:0]      raddr2_i,
    output logic      [XLEN-1:0] rdata1_o,
    output logic      [XLEN-1:0] rdata2_o,
    input  wire logic            we_i,
    input  wire logic [4:0]      waddr_i,
    input  wire logic [XLEN-1:0] wdata_i
);
    localparam int RA_W = $clog2(NREGS);

    logic [XLEN-1:0] regs_q [NREGS];

    // Writes to x0 or beyond the implemented register count are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0) && (32'(waddr_i) < NREGS)) begin
            regs_q[waddr_i[RA_W-1:0]] <= wdata_i;
        end
    end

    assign rdata1_o = ((raddr1_i == 5'd0) || (32'(raddr1_i) >= NREGS)) ? '0
                    : regs_q[raddr1_i[RA_W-1:0]];
    assign rdata2_o = ((raddr2_i == 5'd0) || (32'(raddr2_i) >= NREGS)) ? '0
                    : regs_q[raddr2_i[RA_W-1:0]];

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Instruction-decode stage between IF/ID and ID/EX. Register
//               file, immediate generator, control decode, load-use
//               interlock, flush and a registered ID/EX output with a
//               valid/ready handshake.
// Ports       : clk, reset (active-low async), bus (decode_stage_if.slave)
// Config      : DECODE_WB_BYPASS_EN - forward write-back data straight into
//               the operand registers instead of stalling on a WB/ID
//               register collision.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  wire logic     clk,
    input  wire logic     reset,
    decode_stage_if.slave bus
);
    localparam logic c_RV64 = (XLEN == 64);

    logic [31:0]     w_inst;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    dec_t            w_dec;
    ctrl_t           w_ctrl;
    logic            w_use1;
    logic            w_use2;
    logic            w_idx_bad;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rf1;
    logic [XLEN-1:0] w_rf2;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic            w_wb_hit1;
    logic            w_wb_hit2;
    logic            w_hazard;
    logic            w_collide;
    logic            w_in_ready;
    logic            w_accept;

    logic            valid_d;
    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [4:0]      rd_q;
    logic [2:0]      funct3_q;
    logic [6:0]      funct7_q;
    ctrl_t           ctrl_q;

    assign w_inst = bus.in_inst;
    assign w_rs1  = w_inst[19:15];
    assign w_rs2  = w_inst[24:20];
    assign w_rd   = w_inst[11:7];
    assign w_dec  = decode_inst(w_inst, c_RV64);
    assign w_use1 = fmt_uses_rs1(w_dec.fmt);
    assign w_use2 = fmt_uses_rs2(w_dec.fmt);

    // Only fields that really name a register are range-checked; in U/J
    // formats those bits belong to the immediate.
    assign w_idx_bad = (w_use1 && (32'(w_rs1) >= NREGS))
                    || (w_use2 && (32'(w_rs2) >= NREGS))
                    || (fmt_has_rd(w_dec.fmt) && (32'(w_rd) >= NREGS));

    always_comb begin
        w_ctrl = w_dec.ctrl;
        if (w_idx_bad) begin
            w_ctrl         = '0;
            w_ctrl.illegal = 1'b1;
        end
    end

    always_comb begin
        w_imm32 = '0;
        case (w_dec.fmt)
            FMT_I: w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
            FMT_S: w_imm32 = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            FMT_B: w_imm32 = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                              w_inst[30:25], w_inst[11:8], 1'b0};
            FMT_U: w_imm32 = {w_inst[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                              w_inst[20], w_inst[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_imm_sext
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_imm_direct
            assign w_imm = w_imm32;
        end
    endgenerate

    decode_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .raddr1_i (w_rs1),
        .raddr2_i (w_rs2),
        .rdata1_o (w_rf1),
        .rdata2_o (w_rf2),
        .we_i     (bus.wb_valid),
        .waddr_i  (bus.wb_rd),
        .wdata_i  (bus.wb_data)
    );

    assign w_wb_hit1 = bus.wb_valid && (bus.wb_rd != 5'd0) && (bus.wb_rd == w_rs1);
    assign w_wb_hit2 = bus.wb_valid && (bus.wb_rd != 5'd0) && (bus.wb_rd == w_rs2);

`ifdef DECODE_WB_BYPASS_EN
    assign w_op1     = w_wb_hit1 ? bus.wb_data : w_rf1;
    assign w_op2     = w_wb_hit2 ? bus.wb_data : w_rf2;
    assign w_collide = 1'b0;
`else
    // The register file returns the pre-write value, so an instruction that
    // reads the register being written waits one cycle for the new value.
    assign w_op1     = w_rf1;
    assign w_op2     = w_rf2;
    assign w_collide = (w_use1 && w_wb_hit1) || (w_use2 && w_wb_hit2);
`endif

    assign w_hazard = bus.ex_memread && (bus.ex_rd != 5'd0)
                   && ((w_use1 && (bus.ex_rd == w_rs1)) || (w_use2 && (bus.ex_rd == w_rs2)));

    // Gated with reset so nothing is accepted while reset is held.
    assign w_in_ready = reset && !bus.flush && !w_hazard && !w_collide
                     && (!valid_q || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        valid_d = valid_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (w_accept) begin
            valid_d = 1'b1;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            ctrl_q     <= '0;
        end else begin
            valid_q <= valid_d;
            if (w_accept) begin
                pc_q       <= bus.in_pc;
                rs1_data_q <= w_op1;
                rs2_data_q <= w_op2;
                imm_q      <= w_imm;
                rs1_q      <= w_rs1;
                rs2_q      <= w_rs2;
                rd_q       <= w_rd;
                funct3_q   <= w_inst[14:12];
                funct7_q   <= w_inst[31:25];
                ctrl_q     <= w_ctrl;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = valid_q;
    assign bus.out_pc       = pc_q;
    assign bus.out_rs1_data = rs1_data_q;
    assign bus.out_rs2_data = rs2_data_q;
    assign bus.out_imm      = imm_q;
    assign bus.out_rs1      = rs1_q;
    assign bus.out_rs2      = rs2_q;
    assign bus.out_rd       = rd_q;
    assign bus.out_funct3   = funct3_q;
    assign bus.out_funct7   = funct7_q;
    assign bus.out_branch   = ctrl_q.branch;
    assign bus.out_memread  = ctrl_q.memread;
    assign bus.out_memwrite = ctrl_q.memwrite;
    assign bus.out_memtoreg = ctrl_q.memtoreg;
    assign bus.out_alusrc   = ctrl_q.alusrc;
    assign bus.out_regwrite = ctrl_q.regwrite;
    assign bus.out_aluop    = ctrl_q.aluop;
    assign bus.out_illegal  = ctrl_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage. Directed scenarios with
//               literal expectations, then randomized traffic compared every
//               cycle against a behavioural model of the ID stage. A second
//               instance (XLEN=32, NREGS=16) covers width/index legality.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic clk;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    decode_stage_if #(.XLEN(64)) bus ();
    decode_stage_if #(.XLEN(32)) bus32 ();

    decode_stage #(.XLEN(64), .NREGS(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    decode_stage #(.XLEN(32), .NREGS(16)) dut32 (.clk(clk), .reset(reset), .bus(bus32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit       ill;
        bit [5:0] c6;    // branch, memread, memwrite, memtoreg, alusrc, regwrite
        bit [1:0] aop;
        int       fmt;   // 0 R, 1 I, 2 S, 3 B, 4 U, 5 J
    } mdec_t;

    function automatic mdec_t mdec(input bit [31:0] i);
        mdec_t d;
        d.ill = 0; d.c6 = 6'b0; d.aop = 2'b00; d.fmt = 0;
        case (i[6:0])
            7'h03: begin d.fmt = 1; d.c6 = 6'b010111; end
            7'h23: begin d.fmt = 2; d.c6 = 6'b001010; end
            7'h63: begin d.fmt = 3; d.c6 = 6'b100000; d.aop = 2'b01; end
            7'h6F: begin d.fmt = 5; d.c6 = 6'b000011; end
            7'h67: begin d.fmt = 1; d.c6 = 6'b000011; end
            7'h33, 7'h3B: begin d.fmt = 0; d.c6 = 6'b000001; d.aop = 2'b10; end
            7'h13, 7'h1B: begin d.fmt = 1; d.c6 = 6'b000011; d.aop = 2'b10; end
            7'h37, 7'h17: begin d.fmt = 4; d.c6 = 6'b000011; end
            default: d.ill = 1;
        endcase
        return d;
    endfunction

    function automatic longint m_imm(input bit [31:0] i, input int fmt);
        longint s;
        s = longint'($signed(i));
        case (fmt)
            1: return s >>> 20;
            2: return ((s >>> 25) <<< 5) | longint'(i[11:7]);
            3: return ((s >>> 31) <<< 12) | (longint'(i[7]) << 11)
                    | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1);
            4: return (s >>> 12) <<< 12;
            5: return ((s >>> 31) <<< 20) | (longint'(i[19:12]) << 12)
                    | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1);
            default: return 0;
        endcase
    endfunction

    bit [63:0] m_regs [32];
    bit        e_valid;
    bit [63:0] e_pc, e_r1d, e_r2d, e_imm;
    bit [4:0]  e_rs1, e_rs2, e_rd;
    bit [2:0]  e_f3;
    bit [6:0]  e_f7;
    bit [8:0]  e_ctl;

    function automatic bit m_uses(input bit [31:0] i, input bit [4:0] r, input bit en);
        mdec_t d;
        bit    u1, u2;
        d  = mdec(i);
        u1 = (d.fmt != 4) && (d.fmt != 5);
        u2 = (d.fmt == 0) || (d.fmt == 2) || (d.fmt == 3);
        return en && (r != 0) && ((u1 && r == i[19:15]) || (u2 && r == i[24:20]));
    endfunction

    function automatic bit m_ready();
        bit col;
`ifdef DECODE_WB_BYPASS_EN
        col = 0;
`else
        col = m_uses(bus.in_inst, bus.wb_rd, bus.wb_valid);
`endif
        return reset && !bus.flush && !col
            && !m_uses(bus.in_inst, bus.ex_rd, bus.ex_memread)
            && (!e_valid || bus.out_ready);
    endfunction

    always @(posedge clk or negedge reset) begin : model
        mdec_t     d;
        bit [31:0] i;
        if (!reset) begin
            for (int k = 0; k < 32; k++) m_regs[k] = 0;
            e_valid = 0; e_pc = 0; e_r1d = 0; e_r2d = 0; e_imm = 0;
            e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_f3 = 0; e_f7 = 0; e_ctl = 0;
        end else begin
            i = bus.in_inst;
            if (bus.flush) begin
                e_valid = 0;
            end else if (bus.in_valid && m_ready()) begin
                d       = mdec(i);
                e_valid = 1;
                e_pc    = bus.in_pc;
                e_rs1   = i[19:15];
                e_rs2   = i[24:20];
                e_rd    = i[11:7];
                e_f3    = i[14:12];
                e_f7    = i[31:25];
                e_imm   = m_imm(i, d.fmt);
                e_r1d   = m_regs[e_rs1];
                e_r2d   = m_regs[e_rs2];
`ifdef DECODE_WB_BYPASS_EN
                if (bus.wb_valid && bus.wb_rd != 0 && bus.wb_rd == e_rs1) e_r1d = bus.wb_data;
                if (bus.wb_valid && bus.wb_rd != 0 && bus.wb_rd == e_rs2) e_r2d = bus.wb_data;
`endif
                e_ctl   = d.ill ? 9'b000000001 : {d.c6, d.aop, 1'b0};
            end else if (bus.out_ready) begin
                e_valid = 0;
            end
            if (bus.wb_valid && bus.wb_rd != 0) m_regs[bus.wb_rd] = bus.wb_data;
        end
    end

    always @(negedge clk) begin : compare
        chk("in_ready", {63'b0, bus.in_ready}, {63'b0, m_ready()});
        chk("out_valid", {63'b0, bus.out_valid}, {63'b0, e_valid});
        if (e_valid) begin
            chk("out_pc", bus.out_pc, e_pc);
            chk("out_rs1_data", bus.out_rs1_data, e_r1d);
            chk("out_rs2_data", bus.out_rs2_data, e_r2d);
            chk("out_imm", bus.out_imm, e_imm);
            chk("out_fields", {44'b0, bus.out_rs1, bus.out_rs2, bus.out_rd},
                {44'b0, e_rs1, e_rs2, e_rd});
            chk("out_funct", {54'b0, bus.out_funct3, bus.out_funct7}, {54'b0, e_f3, e_f7});
            chk("out_ctrl", {55'b0, bus.out_branch, bus.out_memread, bus.out_memwrite,
                             bus.out_memtoreg, bus.out_alusrc, bus.out_regwrite,
                             bus.out_aluop, bus.out_illegal}, {55'b0, e_ctl});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit [31:0] rand_inst();
        bit [6:0]  ops [12] = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33,
                                7'h13, 7'h37, 7'h17, 7'h3B, 7'h1B, 7'h7F};
        bit [31:0] i;
        i       = $urandom;
        i[6:0]  = ops[$urandom_range(11)];
        if ($urandom_range(9) != 0) begin
            i[11:7]  = 5'($urandom_range(7));
            i[19:15] = 5'($urandom_range(7));
            i[24:20] = 5'($urandom_range(7));
        end
        return i;
    endfunction

    initial begin : main
        bit hold;
        reset = 1'b0;
        bus.flush = 0; bus.in_valid = 1; bus.in_inst = 32'hFFB00093; bus.in_pc = 64'h0;
        bus.out_ready = 1; bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
        bus.ex_memread = 0; bus.ex_rd = 0;
        bus32.flush = 0; bus32.in_valid = 1; bus32.in_inst = 32'hFFB00093; bus32.in_pc = 32'h0;
        bus32.out_ready = 1; bus32.wb_valid = 0; bus32.wb_rd = 0; bus32.wb_data = 0;
        bus32.ex_memread = 0; bus32.ex_rd = 0;

        // Reset held with a valid instruction present
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
        chk("rst_rs1_data", bus.out_rs1_data, 64'd0);

        step(); reset = 1'b1;
        @(negedge clk);
        chk("addi_in_ready", {63'b0, bus.in_ready}, 64'd1);
        step(); bus.in_valid = 0;
        @(negedge clk);
        chk("addi_valid", {63'b0, bus.out_valid}, 64'd1);
        chk("addi_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFB);
        chk("addi_regwrite", {63'b0, bus.out_regwrite}, 64'd1);
        chk("addi_alusrc", {63'b0, bus.out_alusrc}, 64'd1);
        chk("addi_aluop", {62'b0, bus.out_aluop}, 64'd2);

        // Load-use interlock: ADD x3,x5,x6 behind a load to x5
        step(); bus.in_valid = 1; bus.in_inst = 32'h006281B3; bus.in_pc = 64'h1000;
        bus.ex_memread = 1; bus.ex_rd = 5;
        @(negedge clk);
        chk("lu_in_ready", {63'b0, bus.in_ready}, 64'd0);
        step(); bus.ex_memread = 0;
        @(negedge clk);
        chk("lu_bubble", {63'b0, bus.out_valid}, 64'd0);
        chk("lu_ready_after", {63'b0, bus.in_ready}, 64'd1);

        // Backpressure: next instruction ADDI x2,x0,7 waits behind the ADD
        step(); bus.out_ready = 0; bus.in_inst = 32'h00700113; bus.in_pc = 64'h1004;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {63'b0, bus.in_ready}, 64'd0);
            chk("bp_valid", {63'b0, bus.out_valid}, 64'd1);
            chk("bp_pc", bus.out_pc, 64'h1000);
            chk("bp_regs", {49'b0, bus.out_rd, bus.out_rs1, bus.out_rs2}, {49'b0, 5'd3, 5'd5, 5'd6});
            chk("bp_imm", bus.out_imm, 64'd0);
            step();
        end
        bus.out_ready = 1;
        @(negedge clk);
        chk("bp_release", {63'b0, bus.in_ready}, 64'd1);

        // Flush while ID/EX full and IF/ID valid: ADDI x4,x0,1 must survive
        step(); bus.flush = 1; bus.in_inst = 32'h00100213; bus.in_pc = 64'h1008;
        @(negedge clk);
        chk("bp_next_rd", {59'b0, bus.out_rd}, 64'd2);
        chk("bp_next_imm", bus.out_imm, 64'd7);
        chk("fl_in_ready", {63'b0, bus.in_ready}, 64'd0);
        step(); bus.flush = 0;
        @(negedge clk);
        chk("fl_valid", {63'b0, bus.out_valid}, 64'd0);
        step(); bus.in_valid = 0;
        @(negedge clk);
        chk("fl_kept_rd", {59'b0, bus.out_rd}, 64'd4);
        chk("fl_kept_pc", bus.out_pc, 64'h1008);

        // WB collision: ADD x1,x7,x0 while x7 <= 0x1234
        step(); bus.wb_valid = 1; bus.wb_rd = 7; bus.wb_data = 64'h1234;
        bus.in_valid = 1; bus.in_inst = 32'h000380B3; bus.in_pc = 64'h100C;
`ifdef DECODE_WB_BYPASS_EN
        @(negedge clk);
        chk("wb_in_ready", {63'b0, bus.in_ready}, 64'd1);
        step(); bus.wb_valid = 0; bus.in_valid = 0;
        @(negedge clk);
        chk("wb_rs1_data", bus.out_rs1_data, 64'h1234);
`else
        @(negedge clk);
        chk("wb_in_ready", {63'b0, bus.in_ready}, 64'd0);
        step(); bus.wb_valid = 0;
        @(negedge clk);
        chk("wb_in_ready_next", {63'b0, bus.in_ready}, 64'd1);
        step(); bus.in_valid = 0;
        @(negedge clk);
        chk("wb_rs1_data", bus.out_rs1_data, 64'h1234);
`endif

        // RV32 / 16-register instance
        chk("rv32_imm", {32'b0, bus32.out_imm}, 64'h0000_0000_FFFF_FFFB);
        chk("rv32_legal", {63'b0, bus32.out_illegal}, 64'd0);
        step(); bus32.in_inst = 32'h003100BB;
        step(); bus32.in_inst = 32'h00100A13;
        @(negedge clk);
        chk("rv32_op32_illegal", {63'b0, bus32.out_illegal}, 64'd1);
        chk("rv32_op32_regwrite", {63'b0, bus32.out_regwrite}, 64'd0);
        step(); bus32.in_valid = 0;
        @(negedge clk);
        chk("e_rd20_illegal", {63'b0, bus32.out_illegal}, 64'd1);
        chk("e_rd20_rd", {59'b0, bus32.out_rd}, 64'd20);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            hold = bus.in_valid && !m_ready();
            step();
            if (cyc == 1500) reset = 1'b0;
            if (cyc == 1503) reset = 1'b1;
            if (!hold) begin
                bus.in_valid = ($urandom_range(3) != 0);
                bus.in_inst  = rand_inst();
                bus.in_pc    = {$urandom, $urandom};
            end
            bus.out_ready  = ($urandom_range(3) != 0);
            bus.flush      = ($urandom_range(19) == 0);
            bus.wb_valid   = ($urandom_range(4) < 2);
            bus.wb_rd      = ($urandom_range(9) == 0) ? 5'($urandom) : 5'($urandom_range(7));
            bus.wb_data    = {$urandom, $urandom};
            bus.ex_memread = ($urandom_range(4) == 0);
            bus.ex_rd      = 5'($urandom_range(7));
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
